// File: rtl/qpmm_issue_sched_pkg.sv
// Shared types for the QPMM issue scheduler: multiplier latency,
// operand type and the shadow-pipe entry that rides alongside each product.
package qpmm_issue_sched_pkg;

    localparam int QPMM_LAT    = 12;
    localparam int QPMM_FP_W   = 32;
    localparam int SCHED_ID_W  = 3;
    localparam int SCHED_TAG_W = 6;

    typedef logic [QPMM_FP_W-1:0] qpmm_fp_t;

    typedef struct packed {
        logic                   v;
        logic [SCHED_ID_W-1:0]  id;
        logic [SCHED_TAG_W-1:0] tag;
    } sched_tag_t;

endpackage

// File: rtl/qpmm_issue_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last winner,
// wrapping around; the pointer moves only when something is granted.
module qpmm_rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = PW'((int'(ptr_q) + k) % N);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                ptr_d    = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= PW'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/qpmm_issue_sched.sv
// Round-robin issue scheduler in front of a pipelined QPMM multiplier.
// Define QPMM_SCHED_PERF_EN to add the perf_clr/perf_issue/perf_stall counters.
module qpmm_issue_sched
    import qpmm_issue_sched_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int TAG_W    = SCHED_TAG_W,
    parameter int PIPE_LAT = QPMM_LAT,
    parameter int MAX_OUT  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_valid,
    output logic [N_REQ-1:0] req_ready,
    input  qpmm_fp_t         req_a   [N_REQ],
    input  qpmm_fp_t         req_b   [N_REQ],
    input  logic [TAG_W-1:0] req_tag [N_REQ],
    input  logic             hold,
    output qpmm_fp_t         qpmm_a,
    output qpmm_fp_t         qpmm_b,
    input  qpmm_fp_t         qpmm_z,
    output logic [N_REQ-1:0] rsp_valid,
    output logic [TAG_W-1:0] rsp_tag,
    output qpmm_fp_t         rsp_z,
    output logic             busy
`ifdef QPMM_SCHED_PERF_EN
    ,
    input  logic             perf_clr,
    output logic [31:0]      perf_issue,
    output logic [31:0]      perf_stall
`endif
);
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [CNT_W-1:0] out_cnt_q [N_REQ];
    logic [CNT_W-1:0] out_cnt_d [N_REQ];
    sched_tag_t       iss_q, iss_d;
    sched_tag_t       sh_q [PIPE_LAT];
    sched_tag_t       sh_d [PIPE_LAT];
    sched_tag_t       ret;
    qpmm_fp_t         qpmm_a_q, qpmm_a_d;
    qpmm_fp_t         qpmm_b_q, qpmm_b_d;
    qpmm_fp_t         rsp_z_q, rsp_z_d;
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic [N_REQ-1:0] elig, gnt, retire;
    logic [IDX_W-1:0] gnt_idx;

    assign ret = sh_q[PIPE_LAT-1];

    // A full requester may still issue in the cycle one of its results retires.
    always_comb begin
        retire = '0;
        elig   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            retire[i] = ret.v && (ret.id == SCHED_ID_W'(i));
            elig[i]   = !rst && !hold && req_valid[i] &&
                        ((out_cnt_q[i] < CNT_W'(MAX_OUT)) || retire[i]);
        end
    end

    qpmm_rr_arbiter #(.N(N_REQ)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (elig),
        .gnt (gnt)
    );

    assign req_ready = gnt;

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) gnt_idx = IDX_W'(i);
        end
    end

    always_comb begin
        qpmm_a_d = qpmm_a_q;
        qpmm_b_d = qpmm_b_q;
        iss_d    = '0;
        if (|gnt) begin
            qpmm_a_d  = req_a[gnt_idx];
            qpmm_b_d  = req_b[gnt_idx];
            iss_d.v   = 1'b1;
            iss_d.id  = SCHED_ID_W'(gnt_idx);
            iss_d.tag = SCHED_TAG_W'(req_tag[gnt_idx]);
        end
        sh_d[0] = iss_q;
        for (int k = 1; k < PIPE_LAT; k++) sh_d[k] = sh_q[k-1];
        for (int i = 0; i < N_REQ; i++) begin
            out_cnt_d[i] = out_cnt_q[i] + CNT_W'(gnt[i]) - CNT_W'(retire[i]);
        end
        rsp_valid_d = retire;
        rsp_tag_d   = rsp_tag_q;
        rsp_z_d     = rsp_z_q;
        if (ret.v) begin
            rsp_tag_d = ret.tag[TAG_W-1:0];
            rsp_z_d   = qpmm_z;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) out_cnt_q[i] <= '0;
            for (int k = 0; k < PIPE_LAT; k++) sh_q[k] <= '0;
            iss_q       <= '0;
            qpmm_a_q    <= '0;
            qpmm_b_q    <= '0;
            rsp_valid_q <= '0;
            rsp_tag_q   <= '0;
            rsp_z_q     <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) out_cnt_q[i] <= out_cnt_d[i];
            for (int k = 0; k < PIPE_LAT; k++) sh_q[k] <= sh_d[k];
            iss_q       <= iss_d;
            qpmm_a_q    <= qpmm_a_d;
            qpmm_b_q    <= qpmm_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_z_q     <= rsp_z_d;
        end
    end

    always_comb begin
        busy = iss_q.v | (|rsp_valid_q);
        for (int k = 0; k < PIPE_LAT; k++) busy = busy | sh_q[k].v;
    end

    assign qpmm_a    = qpmm_a_q;
    assign qpmm_b    = qpmm_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_tag   = rsp_tag_q;
    assign rsp_z     = rsp_z_q;

`ifdef QPMM_SCHED_PERF_EN
    logic [31:0] perf_issue_q, perf_issue_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_issue_d = perf_issue_q;
        perf_stall_d = perf_stall_q;
        if (perf_clr) begin
            perf_issue_d = '0;
            perf_stall_d = '0;
        end else begin
            if ((|gnt) && (perf_issue_q != '1)) perf_issue_d = perf_issue_q + 32'd1;
            if ((|req_valid) && !(|gnt) && (perf_stall_q != '1)) begin
                perf_stall_d = perf_stall_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issue_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_issue_q <= perf_issue_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_issue = perf_issue_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_qpmm_issue_sched.sv
// Randomised and directed bench for qpmm_issue_sched against a
// transaction-level model (round-robin pick, per-requester counts, result queue).
module tb_qpmm_issue_sched;
    import qpmm_issue_sched_pkg::*;

    localparam int N    = 4;
    localparam int TW   = SCHED_TAG_W;
    localparam int LAT  = QPMM_LAT;
    localparam int MAXO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_ready;
    qpmm_fp_t      req_a [N];
    qpmm_fp_t      req_b [N];
    logic [TW-1:0] req_tag [N];
    logic          hold = 1'b0;
    qpmm_fp_t      qpmm_a, qpmm_b, qpmm_z;
    logic [N-1:0]  rsp_valid;
    logic [TW-1:0] rsp_tag;
    qpmm_fp_t      rsp_z;
    logic          busy;
`ifdef QPMM_SCHED_PERF_EN
    logic          perf_clr = 1'b0;
    logic [31:0]   perf_issue, perf_stall;
`endif

    always #5 clk = ~clk;

    qpmm_issue_sched #(.N_REQ(N), .TAG_W(TW), .PIPE_LAT(LAT), .MAX_OUT(MAXO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_tag   (req_tag),
        .hold      (hold),
        .qpmm_a    (qpmm_a),
        .qpmm_b    (qpmm_b),
        .qpmm_z    (qpmm_z),
        .rsp_valid (rsp_valid),
        .rsp_tag   (rsp_tag),
        .rsp_z     (rsp_z),
        .busy      (busy)
`ifdef QPMM_SCHED_PERF_EN
        ,
        .perf_clr  (perf_clr),
        .perf_issue(perf_issue),
        .perf_stall(perf_stall)
`endif
    );

    // Stand-in multiplier: LAT register stages, product truncated to operand width.
    function automatic qpmm_fp_t mulref(input qpmm_fp_t a, input qpmm_fp_t b);
        return a * b;
    endfunction

    qpmm_fp_t mp [LAT];
    always @(posedge clk) begin
        mp[0] <= mulref(qpmm_a, qpmm_b);
        for (int k = 1; k < LAT; k++) mp[k] <= mp[k-1];
    end
    assign qpmm_z = mp[LAT-1];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        int            id;
        logic [TW-1:0] tag;
        qpmm_fp_t      z;
        int            left;
    } rec_t;

    rec_t          q[$];
    rec_t          r;
    int            ptr;
    int            cnt [N];
    int            gcnt [N];
    logic [N-1:0]  e_valid, acc;
    logic [TW-1:0] e_tag;
    qpmm_fp_t      e_z, e_a, e_b;
    logic          e_busy;
    int            m_g, m_rid, m_i;

    initial begin
        for (int i = 0; i < N; i++) gcnt[i] = 0;
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ready", 64'(req_ready), 0);
            chk("rst_rsp_valid", 64'(rsp_valid), 0);
            chk("rst_rsp_tag", 64'(rsp_tag), 0);
            chk("rst_rsp_z", 64'(rsp_z), 0);
            chk("rst_qpmm_a", 64'(qpmm_a), 0);
            chk("rst_qpmm_b", 64'(qpmm_b), 0);
            chk("rst_busy", 64'(busy), 0);
            q.delete();
            ptr = N - 1;
            for (int i = 0; i < N; i++) cnt[i] = 0;
            e_valid = '0; e_tag = '0; e_z = '0;
            e_a = '0; e_b = '0; e_busy = 1'b0; acc = '0;
        end else begin
            chk("rsp_valid", 64'(rsp_valid), 64'(e_valid));
            if (e_valid != '0) begin
                chk("rsp_tag", 64'(rsp_tag), 64'(e_tag));
                chk("rsp_z", 64'(rsp_z), 64'(e_z));
            end
            chk("qpmm_a", 64'(qpmm_a), 64'(e_a));
            chk("qpmm_b", 64'(qpmm_b), 64'(e_b));
            chk("busy", 64'(busy), 64'(e_busy));
            m_rid = (q.size() > 0 && q[0].left == 1) ? q[0].id : -1;
            m_g = -1;
            for (int k = 1; k <= N; k++) begin
                m_i = (ptr + k) % N;
                if (m_g < 0 && req_valid[m_i] && !hold &&
                    (cnt[m_i] < MAXO || m_rid == m_i)) m_g = m_i;
            end
            chk("req_ready", 64'(req_ready), (m_g >= 0) ? (64'd1 << m_g) : 64'd0);
            acc = req_ready & req_valid;
            for (int i = 0; i < N; i++) gcnt[i] += int'(acc[i]);
            e_valid = '0;
            if (m_rid >= 0) begin
                e_valid[m_rid] = 1'b1;
                e_tag = q[0].tag;
                e_z   = q[0].z;
                cnt[m_rid]--;
                void'(q.pop_front());
            end
            for (int j = 0; j < q.size(); j++) q[j].left = q[j].left - 1;
            if (m_g >= 0) begin
                r.id = m_g;
                r.tag = req_tag[m_g];
                r.z = mulref(req_a[m_g], req_b[m_g]);
                r.left = LAT + 1;
                q.push_back(r);
                cnt[m_g]++;
                ptr = m_g;
                e_a = req_a[m_g];
                e_b = req_b[m_g];
            end
            e_busy = (q.size() != 0) || (e_valid != '0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic newop(input int i);
        req_a[i]   = $urandom;
        req_b[i]   = $urandom;
        req_tag[i] = TW'($urandom);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            step();
            for (int i = 0; i < N; i++) if (acc[i]) newop(i);
        end
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        req_valid = '0;
        hold = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    int base [N];
    int sum0;

    initial begin
        for (int i = 0; i < N; i++) begin
            req_a[i] = '0; req_b[i] = '0; req_tag[i] = '0;
        end
        repeat (3) step();
        rst = 1'b0;

        // single request from requester 2
        req_valid  = 4'b0100;
        req_a[2]   = 32'd3;
        req_b[2]   = 32'd5;
        req_tag[2] = 6'h15;
        step();
        chk("t1_accept", 64'(acc), 64'h4);
        req_valid = '0;
        for (int n = 1; n <= LAT + 2; n++) begin
            @(negedge clk);
            chk("t1_rsp_timing", 64'(rsp_valid), (n == LAT + 2) ? 64'h4 : 64'h0);
        end
        chk("t1_rsp_tag", 64'(rsp_tag), 64'h15);
        chk("t1_rsp_z", 64'(rsp_z), 64'd15);
        step();

        // four requesters saturating for 40 cycles
        do_reset();
        for (int i = 0; i < N; i++) begin newop(i); base[i] = gcnt[i]; end
        req_valid = '1;
        run(40);
        req_valid = '0;
        for (int i = 0; i < N; i++) chk("t2_grants", 64'(gcnt[i] - base[i]), 64'd10);
        run(LAT + 4);

        // requester 1 runs into its outstanding limit
        do_reset();
        base[1] = gcnt[1];
        newop(1);
        req_valid = 4'b0010;
        run(14);
        chk("t3_grants", 64'(gcnt[1] - base[1]), 64'd9);
        run(10);
        req_valid = '0;
        run(LAT + 4);

        // hold for 5 cycles during saturation
        do_reset();
        for (int i = 0; i < N; i++) newop(i);
        req_valid = '1;
        run(10);
        hold = 1'b1;
        sum0 = gcnt[0] + gcnt[1] + gcnt[2] + gcnt[3];
        run(5);
        chk("t4_hold_grants", 64'(gcnt[0] + gcnt[1] + gcnt[2] + gcnt[3] - sum0), 64'd0);
        hold = 1'b0;
        run(10);
        req_valid = '0;
        run(LAT + 4);

        // reset with work in flight
        do_reset();
        for (int i = 0; i < N; i++) newop(i);
        req_valid = '1;
        run(20);
        chk("t5_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        req_valid = '0;
        #1;
        chk("t5_rst_rsp", 64'(rsp_valid), 0);
        chk("t5_rst_busy", 64'(busy), 0);
        chk("t5_rst_a", 64'(qpmm_a), 0);
        step();
        rst = 1'b0;
        for (int n = 0; n < LAT + 5; n++) begin
            @(negedge clk);
            chk("t5_quiet", 64'(rsp_valid), 0);
        end
        step();
        newop(0);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        run(LAT + 4);

        // random traffic with random hold
        do_reset();
        repeat (1500) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || acc[i]) begin
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                    newop(i);
                end
            end
            hold = ($urandom_range(0, 9) == 0);
            step();
        end
        req_valid = '0;
        hold = 1'b0;
        run(LAT + 4);

`ifdef QPMM_SCHED_PERF_EN
        do_reset();
        for (int i = 0; i < N; i++) newop(i);
        req_valid = '1;
        run(10);
        hold = 1'b1;
        run(3);
        hold = 1'b0;
        req_valid = '0;
        chk("perf_issue", 64'(perf_issue), 64'd10);
        chk("perf_stall", 64'(perf_stall), 64'd3);
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        chk("perf_issue_clr", 64'(perf_issue), 0);
        chk("perf_stall_clr", 64'(perf_stall), 0);
        run(LAT + 4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
